pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
Game-rule stage directly downstream of the ball and right-paddle position logic in the pong top level. Once per video frame it samples ball and paddle positions and detects paddle hits and right-edge misses. It keeps a 3-digit BCD score and a miss budget, and sequences the game through idle, serve, play and game-over. It drives a one-cycle serve request back to the ball logic, and a registered score and status for an on-screen overlay.

Parameters:
PADDLE_X_LEFT, 540, left edge of right paddle (pixels)
PADDLE_X_RIGHT, 550, right edge of right paddle
PADDLE_HALF, 20, paddle half-height
BALL_HALF, 5, ball half-size
MISS_X, 630, ball_x_pos at or beyond this counts as a miss
MAX_MISSES, 3, miss budget per game (1..3)
SERVE_DELAY_FRAMES, 60, frames between serve arm and serve pulse (1..255)

Ports:
clk  in  1  pixel clock, same clock as the VGA counters
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, produced at the vsync start
ball_x_pos  in  10  ball centre x
ball_y_pos  in  10  ball centre y
paddle_y_pos  in  10  right paddle centre y
start_btn  in  1  level; already synchronised upstream
serve  out  1  one-cycle pulse: ball logic recentres and launches
play_active  out  1  high in PLAY
hit_pulse  out  1  one-cycle pulse per paddle hit
miss_pulse  out  1  one-cycle pulse per miss
score_bcd  out  12  three BCD digits, [11:8] hundreds
misses_left  out  2  remaining misses
game_over  out  1  high in GAME_OVER

Behaviour:
- Decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state is IDLE.
  - score_bcd=0 and misses_left=MAX_MISSES.
  - All pulses are 0. play_active=0 and game_over=0.
  - serve counter=0 and hit_armed=1.
- All outputs are registered. Pulses appear on the cycle after the triggering frame_tick or start_btn sample. Pulses never last more than one cycle.
- FSM states:
  - IDLE: start_btn=1 clears score_bcd to 0, sets misses_left=MAX_MISSES, loads the serve counter with SERVE_DELAY_FRAMES, and moves to SERVE_WAIT.
  - SERVE_WAIT: decrements the counter on each frame_tick. On the frame_tick where the counter reads 1, it asserts serve, sets hit_armed=1, and moves to PLAY.
  - PLAY: evaluated only on frame_tick (see the hit and miss rules below). play_active=1 throughout this state.
  - GAME_OVER: game_over=1. start_btn=1 behaves as in IDLE. A held start_btn restarts immediately; no edge detection is required.
- Arithmetic for the hit and miss tests:
  - Compute all comparisons in 11-bit unsigned by zero-extending the inputs. This prevents wrap for positions near 0 or 1023.
  - |dy| = |ball_y_pos − paddle_y_pos|, computed by choosing the subtraction order.
- Hit: all of the following are true on a frame_tick in PLAY:
  - ball_x_pos+BALL_HALF ≥ PADDLE_X_LEFT
  - ball_x_pos ≤ PADDLE_X_RIGHT
  - |dy| ≤ PADDLE_HALF+BALL_HALF
  - hit_armed=1
- On a hit:
  - hit_pulse=1 and hit_armed clears.
  - score_bcd increments in BCD with digit carries (009→010, 099→100).
  - The score saturates at 999; a hit at 999 still pulses hit_pulse.
- Re-arm: hit_armed sets on any PLAY frame_tick where ball_x_pos+BALL_HALF < PADDLE_X_LEFT. This gives one hit per paddle contact, however many frames the overlap lasts.
- Miss: ball_x_pos ≥ MISS_X on a PLAY frame_tick.
  - miss_pulse=1 and misses_left decrements.
  - If misses_left was 1: it becomes 0 and the state moves to GAME_OVER.
  - Otherwise: the serve counter reloads and the state moves to SERVE_WAIT.
- Simultaneous hit and miss: impossible while MISS_X > PADDLE_X_RIGHT. If a parameter choice allows both, miss has priority and no score is added.
- Positions and frame_tick are ignored outside PLAY (SERVE_WAIT uses frame_tick for its counter only). start_btn is ignored in SERVE_WAIT and PLAY.
- Reset mid-operation: on the next edge, return to the reset values and IDLE, and abort any pending serve.

Test Plan:
1. reset, then start_btn for 1 cycle, then 60 frame_ticks → serve pulses exactly once, the cycle after the 60th tick; play_active=1; misses_left=3; score_bcd=0x000.
2. PLAY with paddle_y=200, ball (540,215) held for 4 frames → exactly one hit_pulse and score=0x001. Move ball to x=500, then back to (540,215) → a second hit, score=0x002.
3. PLAY with paddle_y=200, ball (540,226) → no hit (|dy|=26 > 25). Ball (545,175) → hit (|dy|=25). Paddle_y=10, ball_y=0 → hit, with no underflow false-miss.
4. Preload score to 0x099, then hit → 0x100. Score 0x999, then hit → stays 0x999 and hit_pulse=1.
5. Three misses at ball_x=630 separated by serves → misses_left goes 2, 1, 0; game_over=1 after the third; a fourth frame_tick gives no miss_pulse. Then start_btn → score 0, misses_left=3, SERVE_WAIT.
6. reset asserted in PLAY with score 0x042 → next cycle: score 0, IDLE, all pulses 0; no serve follows without start_btn.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Pong game-rule stage. Once per video frame it samples ball and right-paddle
// positions, detects paddle hits and right-edge misses, keeps a 3-digit BCD
// score plus a miss budget, and sequences IDLE -> SERVE_WAIT -> PLAY -> GAME_OVER.
//
// Ports:
//   clk, reset      pixel clock; synchronous active-high reset
//   frame_tick      one-cycle pulse per frame (vsync start)
//   ball_x_pos/y    ball centre; paddle_y_pos right paddle centre (10 bit)
//   start_btn       level, already synchronised
//   serve           one-cycle pulse: ball logic recentres and launches
//   play_active     high in PLAY;  game_over high in GAME_OVER
//   hit_pulse       one-cycle pulse per paddle hit
//   miss_pulse      one-cycle pulse per miss
//   score_bcd       three BCD digits, [11:8] hundreds
//   misses_left     remaining misses
// All outputs are registered; pulses follow the triggering sample by one cycle.
module pong_score_keeper #(
  parameter int PADDLE_X_LEFT      = 540,
  parameter int PADDLE_X_RIGHT     = 550,
  parameter int PADDLE_HALF        = 20,
  parameter int BALL_HALF          = 5,
  parameter int MISS_X             = 630,
  parameter int MAX_MISSES         = 3,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  ball_x_pos,
  input  logic [9:0]  ball_y_pos,
  input  logic [9:0]  paddle_y_pos,
  input  logic        start_btn,
  output logic        serve,
  output logic        play_active,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [11:0] score_bcd,
  output logic [1:0]  misses_left,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, GAME_OVER} state_t;

  localparam logic [1:0]  MISS_INIT  = 2'(MAX_MISSES);
  localparam logic [7:0]  SERVE_INIT = 8'(SERVE_DELAY_FRAMES);
  localparam logic [11:0] SCORE_MAX  = 12'h999;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        armed, armed_nx;
  logic [11:0] score_nx;
  logic [1:0]  ml_nx;
  logic        serve_nx, hit_nx, miss_nx;

  // 11-bit zero-extended geometry so ball_x+BALL_HALF and |dy| never wrap
  logic [10:0] bx, by, py, bx_r, dy;
  logic        is_hit, is_miss, clear_x, start_go, serve_go;

  assign bx   = {1'b0, ball_x_pos};
  assign by   = {1'b0, ball_y_pos};
  assign py   = {1'b0, paddle_y_pos};
  assign bx_r = bx + 11'(BALL_HALF);
  assign dy   = (by >= py) ? (by - py) : (py - by);

  assign is_miss = (bx >= 11'(MISS_X));
  assign is_hit  = (bx_r >= 11'(PADDLE_X_LEFT)) && (bx <= 11'(PADDLE_X_RIGHT)) &&
                   (dy <= 11'(PADDLE_HALF + BALL_HALF)) && armed;
  // ball fully left of the paddle face: the next overlap counts as a new contact
  assign clear_x = (bx_r < 11'(PADDLE_X_LEFT));

  assign start_go = start_btn && (state == IDLE || state == GAME_OVER);
  // counter reading 1 on a tick means the delay has elapsed (<=1 guards a zero load)
  assign serve_go = (state == SERVE_WAIT) && frame_tick && (cnt <= 8'd1);

  // BCD +1 with digit carries, saturating at 999
  function automatic logic [11:0] bcd_inc(input logic [11:0] s);
    logic [3:0] d2, d1, d0;
    {d2, d1, d0} = s;
    if (s == SCORE_MAX) return s;
    if (d0 != 4'd9) return {d2, d1, d0 + 4'd1};
    if (d1 != 4'd9) return {d2, d1 + 4'd1, 4'd0};
    return {d2 + 4'd1, 8'h00};
  endfunction

  // state + registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      armed       <= 1'b1;
      score_bcd   <= 12'h000;
      misses_left <= MISS_INIT;
      serve       <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      play_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      armed       <= armed_nx;
      score_bcd   <= score_nx;
      misses_left <= ml_nx;
      serve       <= serve_nx;
      hit_pulse   <= hit_nx;
      miss_pulse  <= miss_nx;
      play_active <= (state_nx == PLAY);
      game_over   <= (state_nx == GAME_OVER);
    end
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, GAME_OVER: if (start_btn) state_nx = SERVE_WAIT;
      SERVE_WAIT:      if (serve_go)  state_nx = PLAY;
      PLAY: begin
        if (frame_tick && is_miss)
          state_nx = (misses_left == 2'd1) ? GAME_OVER : SERVE_WAIT;
      end
      default:         state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs and counters
  always_comb begin
    cnt_nx   = cnt;
    armed_nx = armed;
    score_nx = score_bcd;
    ml_nx    = misses_left;
    serve_nx = 1'b0;
    hit_nx   = 1'b0;
    miss_nx  = 1'b0;
    if (start_go) begin
      score_nx = 12'h000;
      ml_nx    = MISS_INIT;
      cnt_nx   = SERVE_INIT;
    end else if (state == SERVE_WAIT && frame_tick) begin
      if (serve_go) begin
        serve_nx = 1'b1;
        armed_nx = 1'b1;
        cnt_nx   = 8'd0;
      end else begin
        cnt_nx = cnt - 8'd1;
      end
    end else if (state == PLAY && frame_tick) begin
      // miss wins over a simultaneous hit
      if (is_miss) begin
        miss_nx = 1'b1;
        ml_nx   = misses_left - 2'd1;
        if (misses_left != 2'd1) cnt_nx = SERVE_INIT;
      end else if (is_hit) begin
        hit_nx   = 1'b1;
        armed_nx = 1'b0;
        score_nx = bcd_inc(score_bcd);
      end else if (clear_x) begin
        armed_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper: each driven cycle pushes its expected
// outputs to a queue, popped and compared one cycle later, #1 after the edge.
module tb_pong_score_keeper;

  logic        clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, start_btn = 1'b0;
  logic [9:0]  ball_x_pos = '0, ball_y_pos = '0, paddle_y_pos = '0;
  logic        serve, play_active, hit_pulse, miss_pulse, game_over;
  logic [11:0] score_bcd;
  logic [1:0]  misses_left;

  pong_score_keeper dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ball_x_pos(ball_x_pos), .ball_y_pos(ball_y_pos), .paddle_y_pos(paddle_y_pos),
    .start_btn(start_btn), .serve(serve), .play_active(play_active),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score_bcd(score_bcd),
    .misses_left(misses_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        hit, miss, srv, play, go;
    logic [11:0] score;
    logic [1:0]  ml;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  // expected levels, set by the directed steps
  int   m_score = 0, m_ml = 3;
  bit   m_play = 0, m_go = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push(input string tag, input logic h, input logic mi, input logic s);
    exp_t e;
    e.tag = tag; e.hit = h; e.miss = mi; e.srv = s;
    e.play = m_play; e.go = m_go; e.score = to_bcd(m_score); e.ml = 2'(m_ml);
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string f, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, f, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard empty at %0t", $time);
    end else begin
      e = q.pop_front();
      chk(e.tag, "hit",   12'(hit_pulse),   12'(e.hit));
      chk(e.tag, "miss",  12'(miss_pulse),  12'(e.miss));
      chk(e.tag, "serve", 12'(serve),       12'(e.srv));
      chk(e.tag, "play",  12'(play_active), 12'(e.play));
      chk(e.tag, "go",    12'(game_over),   12'(e.go));
      chk(e.tag, "score", score_bcd,        e.score);
      chk(e.tag, "ml",    12'(misses_left), 12'(e.ml));
    end
  endtask

  // one tick cycle followed by one quiet cycle, both checked
  task automatic frame(input int x, input int y, input int py,
                       input logic h, input logic mi, input logic s, input string tag);
    ball_x_pos = 10'(x); ball_y_pos = 10'(y); paddle_y_pos = 10'(py);
    frame_tick = 1'b1;
    push(tag, h, mi, s);
    step();
    frame_tick = 1'b0;
    push({tag, "_q"}, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic serve_wait(input string tag);
    for (int i = 1; i <= 60; i++) begin
      if (i == 60) m_play = 1;
      frame(int'(ball_x_pos), int'(ball_y_pos), int'(paddle_y_pos), 1'b0, 1'b0, i == 60, tag);
    end
  endtask

  task automatic rearm();
    frame(500, 215, 200, 1'b0, 1'b0, 1'b0, "rearm");
  endtask

  task automatic hit(input string tag);
    if (m_score < 999) m_score++;
    frame(540, 215, 200, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // 1: reset, start, serve after 60 ticks
    reset = 1'b1;
    push("reset", 1'b0, 1'b0, 1'b0); step();
    reset = 1'b0;
    start_btn = 1'b1;
    push("start", 1'b0, 1'b0, 1'b0); step();
    start_btn = 1'b0;
    serve_wait("serve1");

    // 2: one hit per contact despite a 4-frame overlap
    hit("hold1");
    for (int i = 2; i <= 4; i++) frame(540, 215, 200, 1'b0, 1'b0, 1'b0, "hold_n");
    rearm();
    hit("hit2");

    // 3: |dy| boundary and low-edge positions
    rearm();
    frame(540, 226, 200, 1'b0, 1'b0, 1'b0, "dy26");
    m_score = 3;
    frame(545, 175, 200, 1'b1, 1'b0, 1'b0, "dy25");
    frame(0, 0, 10, 1'b0, 1'b0, 1'b0, "rearm_x0");
    m_score = 4;
    frame(540, 0, 10, 1'b1, 1'b0, 1'b0, "low_edge");

    // 4: carries through 099->100 and saturation at 999
    while (m_score < 99) begin rearm(); hit("climb"); end
    rearm(); hit("to100");
    while (m_score < 999) begin rearm(); hit("climb2"); end
    rearm(); hit("sat999");

    // 5: three misses, game over, restart
    m_ml = 2; m_play = 0;
    frame(630, 215, 200, 1'b0, 1'b1, 1'b0, "miss1");
    serve_wait("serve_m1");
    m_ml = 1; m_play = 0;
    frame(630, 215, 200, 1'b0, 1'b1, 1'b0, "miss2");
    serve_wait("serve_m2");
    m_ml = 0; m_play = 0; m_go = 1;
    frame(630, 215, 200, 1'b0, 1'b1, 1'b0, "miss3");
    frame(630, 215, 200, 1'b0, 1'b0, 1'b0, "miss4_none");
    start_btn = 1'b1;
    m_score = 0; m_ml = 3; m_go = 0;
    push("restart", 1'b0, 1'b0, 1'b0); step();
    start_btn = 1'b0;
    serve_wait("serve_restart");

    // 6: reset mid-play with score 042
    frame(500, 215, 200, 1'b0, 1'b0, 1'b0, "rearm_pre");
    for (int i = 0; i < 42; i++) begin hit("to42"); rearm(); end
    reset = 1'b1;
    m_score = 0; m_play = 0;
    push("mid_reset", 1'b0, 1'b0, 1'b0); step();
    reset = 1'b0;
    for (int i = 0; i < 70; i++) frame(540, 215, 200, 1'b0, 1'b0, 1'b0, "no_serve");

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL leftover observed %0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
